// File: rtl/elevator_actuator_pkg.sv
// Shared encodings for the elevator controller and its actuator stage.
package elevator_pkg;

    localparam logic [1:0] SPD_STOP = 2'b00;
    localparam logic [1:0] SPD_25   = 2'b01;
    localparam logic [1:0] SPD_50   = 2'b10;
    localparam logic [1:0] SPD_75   = 2'b11;

    localparam logic MOT_HOIST = 1'b0;
    localparam logic MOT_DOOR  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_CLOSE = 1'b0;
    localparam logic DIR_OPEN  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD,
        ST_HOIST,
        ST_OPENING,
        ST_DWELL,
        ST_OPEN_WAIT,
        ST_CLOSING
    } act_state_e;

    typedef struct packed {
        logic       m;
        logic       d;
        logic [1:0] spd;
        logic       s;
    } cmd_t;

    // High time in clocks for a speed code: period * k / 4.
    function automatic int unsigned duty_of(int unsigned period, logic [1:0] spd);
        return (period / 4) * 32'(spd);
    endfunction

endpackage

// File: rtl/elevator_actuator_if.sv
// Command inputs and drive outputs between the controller and the actuator.
interface elevator_actuator_if;
    logic m;
    logic d;
    logic p;
    logic w;
    logic s;
    logic hoist_up;
    logic hoist_dn;
    logic door_opn;
    logic door_cls;
    logic buzzer;
    logic r;

    modport master (output m, d, p, w, s,
                    input  hoist_up, hoist_dn, door_opn, door_cls, buzzer, r);
    modport slave  (input  m, d, p, w, s,
                    output hoist_up, hoist_dn, door_opn, door_cls, buzzer, r);
endinterface

// File: rtl/elevator_actuator_pwm_gen.sv
// Free-running PWM counter; duty changes only at a wrap or on clear, so no runt pulses.
module pwm_gen
    import elevator_pkg::*;
#(
    parameter int unsigned PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [1:0] spd,
    output logic       pwm_c
);
    localparam int unsigned CW = $clog2(PERIOD);

    logic [CW-1:0] cnt;
    logic [CW-1:0] duty;
    logic          wrap;

    assign wrap = (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            duty <= '0;
        end else if (clr) begin
            cnt  <= '0;
            duty <= CW'(duty_of(PERIOD, spd));
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) duty <= CW'(duty_of(PERIOD, spd));
        end
    end

    assign pwm_c = (cnt < duty);
endmodule

// File: rtl/elevator_actuator.sv
// Turns controller motor/speed/door codes into gated PWM drives with dead time and door timing.
module elevator_actuator
    import elevator_pkg::*;
#(
    parameter int unsigned PWM_PERIOD       = 100,
    parameter int unsigned DEAD_CYCLES      = 8,
    parameter int unsigned DOOR_MOVE_CYCLES = 2000,
    parameter int unsigned DWELL_CYCLES     = 5000,
    parameter int unsigned BEEP_CYCLES      = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    elevator_actuator_if.slave bus
);
    localparam int unsigned DEAD_W  = $clog2(DEAD_CYCLES + 1);
    localparam int unsigned MOVE_W  = $clog2(DOOR_MOVE_CYCLES + 1);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned BEEP_W  = $clog2(BEEP_CYCLES + 1);

    cmd_t               cmd_q;
    act_state_e         state, state_nx, tgt, tgt_nx, go_tgt;
    logic               hdir, hdir_nx, go_dead;
    logic [1:0]         spd_l, spd_l_nx, door_spd, pwm_spd;
    logic [DEAD_W-1:0]  dead_cnt, dead_nx;
    logic [MOVE_W-1:0]  move_cnt, move_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nx;
    logic [BEEP_W-1:0]  beep_cnt;
    logic               hoist_cmd, open_cmd, close_cmd, pwm_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmd_q <= '0;
        else        cmd_q <= cmd_t'({bus.m, bus.d, bus.p, bus.w, bus.s});
    end

    assign hoist_cmd = (cmd_q.m == MOT_HOIST) && (cmd_q.spd != SPD_STOP);
    assign open_cmd  = (cmd_q.m == MOT_DOOR) && (cmd_q.d == DIR_OPEN);
    assign close_cmd = (cmd_q.m == MOT_DOOR) && (cmd_q.d == DIR_CLOSE);
    assign door_spd  = (cmd_q.spd == SPD_STOP) ? SPD_25 : cmd_q.spd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tgt       <= ST_IDLE;
            hdir      <= 1'b0;
            spd_l     <= SPD_STOP;
            dead_cnt  <= '0;
            move_cnt  <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_nx;
            tgt       <= tgt_nx;
            hdir      <= hdir_nx;
            spd_l     <= spd_l_nx;
            dead_cnt  <= dead_nx;
            move_cnt  <= move_nx;
            dwell_cnt <= dwell_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tgt_nx   = tgt;
        hdir_nx  = hdir;
        spd_l_nx = spd_l;
        dead_nx  = dead_cnt;
        move_nx  = move_cnt;
        dwell_nx = dwell_cnt;
        go_dead  = 1'b0;
        go_tgt   = ST_HOIST;
        case (state)
            ST_IDLE: begin
                if (hoist_cmd) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_HOIST;
                end else if (open_cmd) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_OPENING;
                end else if (close_cmd) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_CLOSING;
                end
            end
            ST_DEAD: begin
                if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
                    state_nx = tgt;
                    move_nx  = '0;
                end else begin
                    dead_nx = dead_cnt + DEAD_W'(1);
                end
            end
            ST_HOIST: begin
                if (cmd_q.m == MOT_DOOR) begin
                    go_dead = 1'b1;
                    go_tgt  = (cmd_q.d == DIR_OPEN) ? ST_OPENING : ST_CLOSING;
                end else if (cmd_q.spd == SPD_STOP) begin
                    state_nx = ST_IDLE;
                end else if (cmd_q.d != hdir) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_HOIST;
                end
            end
            ST_OPENING: begin
                if (close_cmd) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_CLOSING;
                end else if (move_cnt == MOVE_W'(DOOR_MOVE_CYCLES - 1)) begin
                    state_nx = ST_DWELL;
                    dwell_nx = '0;
                end else begin
                    move_nx = move_cnt + MOVE_W'(1);
                end
            end
            ST_DWELL: begin
                if (open_cmd) begin
                    dwell_nx = '0;
                end else if (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1)) begin
                    state_nx = ST_OPEN_WAIT;
                end else begin
                    dwell_nx = dwell_cnt + DWELL_W'(1);
                end
            end
            ST_OPEN_WAIT: begin
                if (close_cmd) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_CLOSING;
                end else if (open_cmd) begin
                    state_nx = ST_DWELL;
                    dwell_nx = '0;
                end
            end
            ST_CLOSING: begin
                if (open_cmd) begin
                    go_dead = 1'b1;
                    go_tgt  = ST_OPENING;
                end else if (move_cnt == MOVE_W'(DOOR_MOVE_CYCLES - 1)) begin
                    state_nx = ST_IDLE;
                end else begin
                    move_nx = move_cnt + MOVE_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Every accepted command passes through DEAD with its target and speed latched.
        if (go_dead) begin
            state_nx = ST_DEAD;
            tgt_nx   = go_tgt;
            dead_nx  = '0;
            if (go_tgt == ST_HOIST) begin
                hdir_nx  = cmd_q.d;
                spd_l_nx = cmd_q.spd;
            end else begin
                spd_l_nx = door_spd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              beep_cnt <= '0;
        else if (cmd_q.s)        beep_cnt <= BEEP_W'(BEEP_CYCLES);
        else if (beep_cnt != '0) beep_cnt <= beep_cnt - BEEP_W'(1);
    end

    assign pwm_spd = (state == ST_HOIST) ? cmd_q.spd : spd_l;

    pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_DEAD),
        .spd   (pwm_spd),
        .pwm_c (pwm_c)
    );

    assign bus.hoist_up = (state == ST_HOIST) && (hdir == DIR_UP) && pwm_c;
    assign bus.hoist_dn = (state == ST_HOIST) && (hdir == DIR_DOWN) && pwm_c;
    assign bus.door_opn = (state == ST_OPENING) && pwm_c;
    assign bus.door_cls = (state == ST_CLOSING) && pwm_c;
    assign bus.buzzer   = (beep_cnt != '0);
    assign bus.r        = (state == ST_OPEN_WAIT);
endmodule

// File: tb/tb_elevator_actuator.sv
// Random and directed stimulus against a timer-based behavioural model of the actuator.
module tb_elevator_actuator;
    localparam int PER    = 8;
    localparam int DEADC  = 2;
    localparam int MOVE   = 16;
    localparam int DWELLC = 10;
    localparam int BEEPC  = 4;

    localparam int MD_IDLE  = 0;
    localparam int MD_DEAD  = 1;
    localparam int MD_HOIST = 2;
    localparam int MD_OPEN  = 3;
    localparam int MD_DWELL = 4;
    localparam int MD_WAIT  = 5;
    localparam int MD_CLOSE = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    elevator_actuator_if bus ();

    elevator_actuator #(
        .PWM_PERIOD       (PER),
        .DEAD_CYCLES      (DEADC),
        .DOOR_MOVE_CYCLES (MOVE),
        .DWELL_CYCLES     (DWELLC),
        .BEEP_CYCLES      (BEEPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: remaining-time counters plus elapsed-time PWM phase.
    int       md, tgt, tgt_spd, dead_left, stroke_left, dwell_left, beep_left, elapsed, duty_cur;
    logic     hdir;
    logic     q_m, q_d, q_s;
    logic [1:0] q_spd;

    function automatic int duty(input logic [1:0] s);
        return PER * int'(s) / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md = MD_IDLE; tgt = MD_IDLE; tgt_spd = 0; dead_left = 0; stroke_left = 0;
        dwell_left = 0; beep_left = 0; elapsed = 0; duty_cur = 0; hdir = 1'b0;
        q_m = 1'b0; q_d = 1'b0; q_s = 1'b0; q_spd = 2'b00;
    endtask

    task automatic go_dead(input int t);
        md = MD_DEAD;
        dead_left = DEADC;
        tgt = t;
        if (t == MD_HOIST) begin
            tgt_spd = int'(q_spd);
            hdir = q_d;
        end else begin
            tgt_spd = (q_spd == 2'b00) ? 1 : int'(q_spd);
        end
    endtask

    task automatic model_step(input logic m, input logic d, input logic [1:0] spd, input logic s);
        logic hc, oc, cc;
        hc = !q_m && (q_spd != 2'b00);
        oc = q_m && q_d;
        cc = q_m && !q_d;
        if (q_s) beep_left = BEEPC;
        else if (beep_left > 0) beep_left--;
        case (md)
            MD_IDLE: begin
                if (hc) go_dead(MD_HOIST);
                else if (oc) go_dead(MD_OPEN);
                else if (cc) go_dead(MD_CLOSE);
            end
            MD_DEAD: begin
                dead_left--;
                if (dead_left == 0) begin
                    md = tgt; elapsed = 0; duty_cur = duty(2'(tgt_spd)); stroke_left = MOVE;
                end
            end
            MD_HOIST: begin
                if (q_m) go_dead(q_d ? MD_OPEN : MD_CLOSE);
                else if (q_spd == 2'b00) md = MD_IDLE;
                else if (q_d != hdir) go_dead(MD_HOIST);
                else begin
                    elapsed++;
                    if (elapsed % PER == 0) duty_cur = duty(q_spd);
                end
            end
            MD_OPEN: begin
                if (cc) go_dead(MD_CLOSE);
                else begin
                    stroke_left--; elapsed++;
                    if (stroke_left == 0) begin md = MD_DWELL; dwell_left = DWELLC; end
                end
            end
            MD_DWELL: begin
                if (oc) dwell_left = DWELLC;
                else begin
                    dwell_left--;
                    if (dwell_left == 0) md = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (cc) go_dead(MD_CLOSE);
                else if (oc) begin md = MD_DWELL; dwell_left = DWELLC; end
            end
            MD_CLOSE: begin
                if (oc) go_dead(MD_OPEN);
                else begin
                    stroke_left--; elapsed++;
                    if (stroke_left == 0) md = MD_IDLE;
                end
            end
            default: md = MD_IDLE;
        endcase
        q_m = m; q_d = d; q_spd = spd; q_s = s;
    endtask

    task automatic check_outputs();
        logic pw;
        pw = (elapsed % PER) < duty_cur;
        chk("hoist_up", 32'(bus.hoist_up), 32'(md == MD_HOIST && hdir && pw));
        chk("hoist_dn", 32'(bus.hoist_dn), 32'(md == MD_HOIST && !hdir && pw));
        chk("door_opn", 32'(bus.door_opn), 32'(md == MD_OPEN && pw));
        chk("door_cls", 32'(bus.door_cls), 32'(md == MD_CLOSE && pw));
        chk("buzzer",   32'(bus.buzzer),   32'(beep_left > 0));
        chk("r",        32'(bus.r),        32'(md == MD_WAIT));
        chk("hoist_excl", 32'(bus.hoist_up & bus.hoist_dn), 32'(0));
    endtask

    // Called just after a falling edge: drive, clock, then compare on the next falling edge.
    task automatic cyc(input logic m, input logic d, input logic [1:0] spd, input logic s);
        bus.m = m; bus.d = d; bus.p = spd[1]; bus.w = spd[0]; bus.s = s;
        @(posedge clk);
        model_step(m, d, spd, s);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n_hu, n_do, n_dc, r_seen, n_run, held_d, held_spd, sel;
        logic s_r;
        rst_n = 1'b0;
        bus.m = 1'b0; bus.d = 1'b0; bus.p = 1'b0; bus.w = 1'b0; bus.s = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        idle_cycles(3);

        // Hoist up at 75 % for 40 cycles.
        n_hu = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, 2'b11, 1'b0);
            n_hu += int'(bus.hoist_up);
        end
        n_run = 40 - 1 - DEADC;
        chk("hoist_up_count", 32'(n_hu), 32'((n_run / PER) * 6 + ((n_run % PER) < 6 ? n_run % PER : 6)));
        // Direction flip, then stop.
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 2'b01, 1'b0);
        idle_cycles(4);

        // Open stroke, dwell, R, hoist ignored, chime retrigger, close stroke.
        n_do = 0;
        cyc(1'b1, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 34; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 1'b0);
            n_do += int'(bus.door_opn);
        end
        chk("door_opn_count", 32'(n_do), 32'((MOVE / PER) * (PER / 4)));
        chk("r_open_wait", 32'(bus.r), 32'(1));
        n_hu = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'b11, 1'b0);
            n_hu += int'(bus.hoist_up) + int'(bus.hoist_dn);
        end
        chk("hoist_ignored", 32'(n_hu), 32'(0));
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        idle_cycles(2);
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        idle_cycles(8);
        chk("r_still_held", 32'(bus.r), 32'(1));
        n_dc = 0;
        cyc(1'b1, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 1'b0);
            n_dc += int'(bus.door_cls);
        end
        chk("door_cls_count", 32'(n_dc), 32'((MOVE / PER) * (PER / 4)));
        chk("r_after_close", 32'(bus.r), 32'(0));

        // Close during the fifth opening cycle: R never asserts.
        r_seen = 0;
        cyc(1'b1, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 1'b0);
            r_seen += int'(bus.r);
        end
        chk("r_never", 32'(r_seen), 32'(0));

        // Reset mid-dwell.
        cyc(1'b1, 1'b1, 2'b00, 1'b0);
        idle_cycles(1 + DEADC + MOVE + 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({bus.hoist_up, bus.hoist_dn, bus.door_opn, bus.door_cls, bus.buzzer, bus.r}), 32'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(6);

        // Random command mix.
        held_d = 0; held_spd = 0;
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 99));
            s_r = ($urandom_range(0, 19) == 0);
            if (sel < 5)
                cyc(1'b1, 1'b1, 2'($urandom_range(0, 3)), s_r);
            else if (sel < 10)
                cyc(1'b1, 1'b0, 2'($urandom_range(0, 3)), s_r);
            else begin
                if (sel < 15) begin
                    held_d = int'($urandom_range(0, 1));
                    held_spd = int'($urandom_range(0, 3));
                end
                cyc(1'b0, 1'(held_d), 2'(held_spd), s_r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elevator_actuator.md
# elevator_actuator

Downstream stage of the elevator controller FSM. Consumes its encoded motor/direction/speed/buzzer outputs (M, D, P, W, S) and turns them into gated PWM drives for the hoist and door motors, with dead time between motor/direction changes. Stretches the controller's one-cycle door commands into timed door moves, times the door-open dwell, and returns the dwell-expired flag R to the controller.

## Interface
- PWM_PERIOD, 100: PWM period in clocks; multiple of 4, ≥4.
- DEAD_CYCLES, 8: all-drives-off cycles before any motor (re)start; ≥1.
- DOOR_MOVE_CYCLES, 2000: duration of one door open or close stroke; ≥1.
- DWELL_CYCLES, 5000: door-open hold time before R asserts; ≥1.
- BEEP_CYCLES, 500: buzzer length per S pulse; ≥1.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- M  in  1  motor select from controller: 0 hoist, 1 door.
- D  in  1  direction: hoist 0 down / 1 up; door 0 close / 1 open.
- P, W  in  1 each  speed code {P,W}: 00 stop, 01 25 %, 10 50 %, 11 75 %.
- S  in  1  pre-open chime request (one-cycle pulse).
- HoistUp, HoistDn  out  1 each  hoist PWM drives.
- DoorOpn, DoorCls  out  1 each  door PWM drives.
- Buzzer  out  1  chime output.
- R  out  1  dwell expired; held until a close command is accepted.

## Operation
- M, D, P, W, S registered once on entry (cmd_q); all decisions use cmd_q.
- Hoist command: cmd_q.M=0 and speed≠00. Open command: cmd_q = {M,D}=11, any speed. Close command: {M,D}=10.
- Stroke speed: hoist tracks current cmd_q speed; door uses the speed latched at command acceptance; door speed 00 is treated as 01.
- FSM states: IDLE, DEAD, HOIST, OPENING, DWELL, OPEN_WAIT, CLOSING.
- IDLE: hoist or door command → latch target channel and speed → DEAD.
- DEAD: all four drives 0 for DEAD_CYCLES cycles, then go to the target state (HOIST, OPENING or CLOSING). PWM counter is cleared on exit.
- HOIST: drive HoistUp (D=1) or HoistDn (D=0).
  - Speed 00 → IDLE.
  - Direction change or door command → DEAD with the new target.
- OPENING: DoorOpn PWM for DOOR_MOVE_CYCLES cycles, then DWELL (dwell counter cleared).
  - Close command during OPENING → DEAD → CLOSING.
- DWELL: after DWELL_CYCLES cycles → OPEN_WAIT.
- OPEN_WAIT: R=1. Close command → DEAD → CLOSING; R clears on the cycle the command is accepted.
- CLOSING: DoorCls PWM for DOOR_MOVE_CYCLES cycles, then IDLE.
  - Open command during CLOSING → DEAD → OPENING (re-open).
- Hoist commands are ignored in OPENING, DWELL, OPEN_WAIT and CLOSING. The door is never moving while the hoist runs.
- Open command in DWELL or OPEN_WAIT restarts DWELL; R drops.
- PWM counter counts 0..PWM_PERIOD-1 and wraps. Drive = (cnt < duty), duty = PWM_PERIOD·k/4 with k = 1, 2, 3.
- In HOIST, a speed change is applied at the next counter wrap, so no runt pulses.
- Only the drive belonging to the active state and direction may be high; the other three are forced 0.
- Buzzer: S in cmd_q loads the beep counter to BEEP_CYCLES; Buzzer=1 while the counter is nonzero. A retrigger reloads it. Independent of the FSM.

## Timing
- Reset (asynchronous, Reset=0): FSM=IDLE; all counters 0; cmd_q=0; HoistUp=HoistDn=DoorOpn=DoorCls=Buzzer=R=0.
- Command present before edge k:
  - edge k: captured in cmd_q;
  - edge k+1: DEAD;
  - edge k+1+DEAD_CYCLES: run state, first high drive in the following cycle.
- Outputs are a combinational decode of registered state/counters only. No input-to-output combinational path.
- R rises in the cycle after the DWELL→OPEN_WAIT edge.
- Buzzer rises 2 cycles after the S pulse and lasts exactly BEEP_CYCLES cycles.

## Structure
- Shared package elevator_pkg:
  - speed code constants SPD_STOP, SPD_25, SPD_50, SPD_75;
  - M/D encodings (MOT_HOIST, MOT_DOOR, DIR_UP/DOWN/OPEN/CLOSE);
  - actuator FSM state enum.
- One sub-module: pwm_gen (counter, wrap-synchronous duty update, clear input, 2-bit speed in, 1-bit out), instantiated once.

## Test plan
Bench parameters: PWM_PERIOD=8, DEAD_CYCLES=2, DOOR_MOVE_CYCLES=16, DWELL_CYCLES=10, BEEP_CYCLES=4.
- Hoist at speed 11, D=1, held 40 cycles → HoistUp low 2 dead cycles, then 6 high / 2 low per period; other drives always 0.
- Hoist direction flipped mid-run → both hoist drives 0 for exactly 2 cycles, then HoistDn PWM; never HoistUp and HoistDn high together.
- One-cycle {M,D,P,W}=1101 → DoorOpn PWM 2 high / 6 low for 16 cycles; R=1 10 cycles later; R held until a one-cycle 1001, then DoorCls for 16 cycles, then IDLE.
- Close command in the 5th OPENING cycle → 2 dead cycles, then DoorCls stroke; R never asserts.
- Hoist command in OPEN_WAIT → ignored; S pulse → Buzzer high 4 cycles; S again after 2 cycles → Buzzer stays high 4 more cycles.
- Reset=0 asserted mid-DWELL → all outputs 0 immediately; after release, IDLE with no drive until a new command.
